// File: rtl/knn_distance_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : knn_distance_sequencer                                        |
// | Purpose  : Job controller for one KNN distance accumulator. On start it  |
// |            streams the query vector against P training vectors out of    |
// |            two 1-cycle-latency read memories, flushes the accumulator    |
// |            pipeline with three zero beats, forwards one tagged distance  |
// |            per training point and pulses job_done at the end.            |
// | Ports    : clk, reset (async, active-high)                               |
// |            start, num_points          - job request (P, 0 = ignored)     |
// |            busy, job_done             - job status                       |
// |            q_rd_en/q_addr/q_rdata     - query memory read port           |
// |            t_rd_en/t_addr/t_rdata     - training memory read port        |
// |            acc_*                      - accumulator interface            |
// |            res_valid/res_distance/res_index - result stream              |
// |            best_distance/best_index   - nearest point so far (optional)  |
// | Options  : define KNN_SEQ_NEAREST_TRACK_EN to add nearest-point tracking |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module knn_distance_sequencer #(
  parameter int dataWidth          = 32,
  parameter int numberOfDimensions = 32,
  parameter int pointIdxWidth      = 10,
  parameter int trainAddrWidth     = 15
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [pointIdxWidth-1:0]              num_points,
  output logic                                  busy,
  output logic                                  job_done,
  output logic                                  q_rd_en,
  output logic [$clog2(numberOfDimensions)-1:0] q_addr,
  input  logic [dataWidth-1:0]                  q_rdata,
  output logic                                  t_rd_en,
  output logic [trainAddrWidth-1:0]             t_addr,
  input  logic [dataWidth-1:0]                  t_rdata,
  output logic                                  acc_reset,
  output logic                                  acc_dataIn_Valid,
  output logic [dataWidth-1:0]                  acc_data1,
  output logic [dataWidth-1:0]                  acc_data2,
  output logic                                  acc_done,
  input  logic [dataWidth-1:0]                  acc_distance,
  input  logic                                  acc_distanceValid,
  output logic                                  res_valid,
  output logic [dataWidth-1:0]                  res_distance,
`ifdef KNN_SEQ_NEAREST_TRACK_EN
  output logic [dataWidth-1:0]                  best_distance,
  output logic [pointIdxWidth-1:0]              best_index,
`endif
  output logic [pointIdxWidth-1:0]              res_index
);

  localparam int DIM_W = $clog2(numberOfDimensions);
  localparam logic [DIM_W-1:0] LAST_D = DIM_W'(numberOfDimensions - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                    state, next_state;
  logic [pointIdxWidth-1:0]  num_pts;
  logic [pointIdxWidth-1:0]  last_p;
  logic [DIM_W-1:0]          d_cnt;
  logic [pointIdxWidth-1:0]  p_cnt;
  logic [trainAddrWidth-1:0] t_cnt;
  logic [1:0]                flush_cnt;
  logic                      flush_d;     // current valid beat is a flush beat
  logic                      valid_prev;  // acc_dataIn_Valid one cycle ago
  logic [pointIdxWidth-1:0]  res_count;
  logic                      issue;
  logic                      capture;

  assign last_p  = num_pts - pointIdxWidth'(1);
  assign issue   = (state == STREAM) || (state == FLUSH);
  // A result is only genuine if it follows a valid beat; this rejects stale
  // strobes from an accumulator that has already stopped.
  assign capture = acc_distanceValid && valid_prev &&
                   ((state == STREAM) || (state == FLUSH) || (state == DRAIN));

  assign q_addr    = d_cnt;
  assign t_addr    = t_cnt;
  // Memory data lines up with the delayed valid; flush beats carry zeros.
  assign acc_data1 = (acc_dataIn_Valid && !flush_d) ? q_rdata : '0;
  assign acc_data2 = (acc_dataIn_Valid && !flush_d) ? t_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b1;
    job_done   = 1'b0;
    q_rd_en    = 1'b0;
    t_rd_en    = 1'b0;
    acc_reset  = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        acc_reset = 1'b1;
        if (start && (num_points != '0)) next_state = CLEAR;
      end
      CLEAR: begin
        acc_reset  = 1'b1;
        next_state = STREAM;
      end
      STREAM: begin
        q_rd_en = 1'b1;
        t_rd_en = 1'b1;
        if ((d_cnt == LAST_D) && (p_cnt == last_p)) next_state = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == 2'd2) next_state = DRAIN;
      end
      DRAIN: begin
        // The result being presented this cycle counts toward P.
        if ((res_count == num_pts) || (res_valid && (res_count == last_p)))
          next_state = DONE;
      end
      DONE: begin
        job_done   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_pts          <= '0;
      d_cnt            <= '0;
      p_cnt            <= '0;
      t_cnt            <= '0;
      flush_cnt        <= '0;
      flush_d          <= 1'b0;
      valid_prev       <= 1'b0;
      res_count        <= '0;
      acc_dataIn_Valid <= 1'b0;
      acc_done         <= 1'b0;
      res_valid        <= 1'b0;
      res_distance     <= '0;
      res_index        <= '0;
    end else begin
      if ((state == IDLE) && start && (num_points != '0)) num_pts <= num_points;

      if (state == CLEAR) begin
        d_cnt     <= '0;
        p_cnt     <= '0;
        t_cnt     <= '0;
        flush_cnt <= '0;
        res_count <= '0;
      end else begin
        if (state == STREAM) begin
          t_cnt <= t_cnt + trainAddrWidth'(1);
          if (d_cnt == LAST_D) begin
            d_cnt <= '0;
            p_cnt <= p_cnt + pointIdxWidth'(1);
          end else begin
            d_cnt <= d_cnt + DIM_W'(1);
          end
        end
        if (state == FLUSH) flush_cnt <= flush_cnt + 2'd1;
        if (res_valid) res_count <= res_count + pointIdxWidth'(1);
      end

      acc_dataIn_Valid <= issue;
      flush_d          <= (state == FLUSH);
      valid_prev       <= acc_dataIn_Valid;
      // Rises with the first flush beat, falls as DRAIN is left.
      acc_done         <= (state == FLUSH) ||
                          ((state == DRAIN) && (next_state == DRAIN));

      res_valid <= capture;
      if (capture) begin
        res_distance <= acc_distance;
        res_index    <= res_count;
      end
    end
  end

`ifdef KNN_SEQ_NEAREST_TRACK_EN
  // Strict less-than keeps the earlier (lower) index on ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_distance <= '0;
      best_index    <= '0;
    end else if (state == CLEAR) begin
      best_distance <= '1;
      best_index    <= '1;
    end else if (res_valid && (res_distance < best_distance)) begin
      best_distance <= res_distance;
      best_index    <= res_index;
    end
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_knn_distance_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_knn_distance_sequencer                                     |
// | Purpose  : Directed self-checking bench for knn_distance_sequencer with  |
// |            N=4, behavioural memories and a behavioural accumulator.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_knn_distance_sequencer;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int PW = 10;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [PW-1:0] num_points = '0;
  logic          busy, job_done, q_rd_en, t_rd_en;
  logic [1:0]    q_addr;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] q_rdata = '0, t_rdata = '0;
  logic          acc_reset, acc_dataIn_Valid, acc_done;
  logic [DW-1:0] acc_data1, acc_data2;
  logic [DW-1:0] acc_distance = '0;
  logic          acc_distanceValid = 1'b0;
  logic          res_valid;
  logic [DW-1:0] res_distance;
  logic [PW-1:0] res_index;
`ifdef KNN_SEQ_NEAREST_TRACK_EN
  logic [DW-1:0] best_distance;
  logic [PW-1:0] best_index;
`endif

  always #5 clk = ~clk;

  knn_distance_sequencer #(
    .dataWidth(DW), .numberOfDimensions(N), .pointIdxWidth(PW), .trainAddrWidth(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_points(num_points),
    .busy(busy), .job_done(job_done),
    .q_rd_en(q_rd_en), .q_addr(q_addr), .q_rdata(q_rdata),
    .t_rd_en(t_rd_en), .t_addr(t_addr), .t_rdata(t_rdata),
    .acc_reset(acc_reset), .acc_dataIn_Valid(acc_dataIn_Valid),
    .acc_data1(acc_data1), .acc_data2(acc_data2), .acc_done(acc_done),
    .acc_distance(acc_distance), .acc_distanceValid(acc_distanceValid),
    .res_valid(res_valid), .res_distance(res_distance),
`ifdef KNN_SEQ_NEAREST_TRACK_EN
    .best_distance(best_distance), .best_index(best_index),
`endif
    .res_index(res_index)
  );

  // Synchronous-read memories.
  logic [DW-1:0] qmem [0:3];
  logic [DW-1:0] tmem [0:63];
  always @(posedge clk) begin
    if (q_rd_en) q_rdata <= qmem[q_addr];
    if (t_rd_en) t_rdata <= tmem[t_addr[5:0]];
  end

  // Behavioural accumulator: result of vector j (1-based) registered after
  // valid beat j*N+3; stops after acc_done && acc_distanceValid.
  int beat;
  int sums [0:31];
  bit stopped;
  always @(posedge clk) begin
    if (acc_reset) begin
      beat = 0;
      stopped = 0;
      for (int i = 0; i < 32; i++) sums[i] = 0;
      acc_distanceValid <= 1'b0;
    end else begin
      acc_distanceValid <= 1'b0;
      if (acc_done && acc_distanceValid) stopped = 1;
      if (acc_dataIn_Valid && !stopped) begin
        int vi, diff;
        beat = beat + 1;
        vi = (beat - 1) / N;
        diff = int'(acc_data1) - int'(acc_data2);
        if (vi < 32) sums[vi] = sums[vi] + diff * diff;
        if (beat > 3 && ((beat - 3) % N) == 0) begin
          acc_distanceValid <= 1'b1;
          acc_distance      <= DW'(sums[(beat - 3) / N - 1]);
        end
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  // Per-job record filled by run_job.
  int      res_n, done_n, done_cyc, last_res_cyc, taddr_n;
  int      res_idx [0:63];
  int      res_dist [0:63];
  int      taddr_seq [0:63];
  logic    busy_after;
`ifdef KNN_SEQ_NEAREST_TRACK_EN
  logic [DW-1:0] best_d_at_done;
  logic [PW-1:0] best_i_at_done;
`endif

  task automatic load_basic();
    int pts [0:11];
    pts = '{1,2,3,4, 2,4,6,8, 0,0,0,0};
    for (int i = 0; i < 4; i++) qmem[i] = DW'(i + 1);
    for (int i = 0; i < 64; i++) tmem[i] = '0;
    for (int i = 0; i < 12; i++) tmem[i] = DW'(pts[i]);
  endtask

  // Starts a job (start seen at the next edge = edge 0), records everything
  // until the cycle after job_done. glitch_cyc pulses start with P=7 there.
  task automatic run_job(input int np, input int glitch_cyc);
    res_n = 0; done_n = 0; done_cyc = -1; last_res_cyc = -1; taddr_n = 0;
    busy_after = 1'bx;
    num_points = PW'(np);
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (res_valid) begin
        if (res_n < 64) begin
          res_idx[res_n]  = int'(res_index);
          res_dist[res_n] = int'(res_distance);
        end
        res_n++;
        last_res_cyc = c;
      end
      if (t_rd_en) begin
        if (taddr_n < 64) taddr_seq[taddr_n] = int'(t_addr);
        taddr_n++;
      end
      if (job_done) begin
        done_n++;
        done_cyc = c;
`ifdef KNN_SEQ_NEAREST_TRACK_EN
        best_d_at_done = best_distance;
        best_i_at_done = best_index;
`endif
      end
      if (c == 1) start = 1'b0;
      if (c == glitch_cyc) begin
        start = 1'b1; num_points = PW'(7);
      end else if (c == glitch_cyc + 1) begin
        start = 1'b0; num_points = PW'(np);
      end
      if (done_n > 0 && !job_done) begin
        busy_after = busy;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (acc_reset !== 1'b1) begin n_err++; $display("FAIL reset_acc_reset: got %b want 1", acc_reset); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({job_done, q_rd_en, t_rd_en, acc_dataIn_Valid, acc_done, res_valid} !== 6'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b want 000000", {job_done, q_rd_en, t_rd_en, acc_dataIn_Valid, acc_done, res_valid});
    end
    n_cmp++; if ({t_addr, res_distance, res_index, acc_data1, acc_data2} !== '0) begin
      n_err++; $display("FAIL reset_buses: t_addr %0d res_d %0d res_i %0d want all 0", t_addr, res_distance, res_index);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_basic_results(input string tag);
    int exp_d [0:2];
    exp_d = '{0, 30, 30};
    n_cmp++; if (res_n !== 3) begin n_err++; $display("FAIL %s_res_count: got %0d want 3", tag, res_n); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (res_idx[i] !== i) begin n_err++; $display("FAIL %s_idx%0d: got %0d want %0d", tag, i, res_idx[i], i); end
      n_cmp++; if (res_dist[i] !== exp_d[i]) begin n_err++; $display("FAIL %s_dist%0d: got %0d want %0d", tag, i, res_dist[i], exp_d[i]); end
    end
    n_cmp++; if (done_n !== 1) begin n_err++; $display("FAIL %s_done_count: got %0d want 1", tag, done_n); end
    n_cmp++; if (done_cyc !== 20) begin n_err++; $display("FAIL %s_done_cycle: got %0d want 20", tag, done_cyc); end
  endtask

  task automatic test_basic_job();
    load_basic();
    run_job(3, -10);
    check_basic_results("basic");
    n_cmp++; if (last_res_cyc !== 19) begin n_err++; $display("FAIL basic_last_res_cycle: got %0d want 19", last_res_cyc); end
    n_cmp++; if (taddr_n !== 12) begin n_err++; $display("FAIL basic_taddr_count: got %0d want 12", taddr_n); end
    for (int i = 0; i < 12 && i < taddr_n; i++) begin
      n_cmp++; if (taddr_seq[i] !== i) begin n_err++; $display("FAIL basic_taddr%0d: got %0d want %0d", i, taddr_seq[i], i); end
    end
  endtask

  task automatic test_back_to_back();
    load_basic();
    run_job(3, -10);
    check_basic_results("b2b_first");
    n_cmp++; if (busy_after !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap: busy got %b want 0", busy_after); end
    run_job(3, -10);
    check_basic_results("b2b_second");
  endtask

  task automatic test_zero_points();
    logic seen;
    seen = 1'b0;
    num_points = '0;
    start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      seen = seen | busy | job_done | q_rd_en | t_rd_en;
    end
    start = 1'b0;
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL zero_points_activity: got %b want 0", seen); end
  endtask

  task automatic test_start_during_stream();
    load_basic();
    run_job(3, 5);
    n_cmp++; if (res_n !== 3) begin n_err++; $display("FAIL glitch_res_count: got %0d want 3", res_n); end
    n_cmp++; if (done_n !== 1) begin n_err++; $display("FAIL glitch_done_count: got %0d want 1", done_n); end
    n_cmp++; if (taddr_n !== 12) begin n_err++; $display("FAIL glitch_taddr_count: got %0d want 12", taddr_n); end
    for (int i = 0; i < 12 && i < taddr_n; i++) begin
      n_cmp++; if (taddr_seq[i] !== i) begin n_err++; $display("FAIL glitch_taddr%0d: got %0d want %0d", i, taddr_seq[i], i); end
    end
  endtask

  task automatic test_reset_mid_stream();
    logic seen;
    load_basic();
    num_points = PW'(3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (acc_reset !== 1'b1) begin n_err++; $display("FAIL midrst_acc_reset: got %b want 1", acc_reset); end
    n_cmp++; if ({busy, q_rd_en, t_rd_en, acc_dataIn_Valid, acc_done, res_valid} !== 6'b0) begin
      n_err++; $display("FAIL midrst_outputs: got %b want 000000", {busy, q_rd_en, t_rd_en, acc_dataIn_Valid, acc_done, res_valid});
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      seen = seen | res_valid | job_done;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_result: got %b want 0", seen); end
    run_job(3, -10);
    check_basic_results("after_rst");
  endtask

`ifdef KNN_SEQ_NEAREST_TRACK_EN
  task automatic test_nearest_track();
    int pts [0:15];
    int exp_d [0:3];
    pts = '{4,2,3,4, 3,2,3,4, 3,2,3,4, 3,3,4,5};
    exp_d = '{9, 4, 4, 7};
    for (int i = 0; i < 4; i++) qmem[i] = DW'(i + 1);
    for (int i = 0; i < 16; i++) tmem[i] = DW'(pts[i]);
    run_job(4, -10);
    n_cmp++; if (res_n !== 4) begin n_err++; $display("FAIL best_res_count: got %0d want 4", res_n); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (res_dist[i] !== exp_d[i]) begin n_err++; $display("FAIL best_dist%0d: got %0d want %0d", i, res_dist[i], exp_d[i]); end
    end
    n_cmp++; if (best_d_at_done !== DW'(4)) begin n_err++; $display("FAIL best_distance: got %0d want 4", best_d_at_done); end
    n_cmp++; if (best_i_at_done !== PW'(1)) begin n_err++; $display("FAIL best_index: got %0d want 1", best_i_at_done); end
    n_cmp++; if (best_index !== PW'(1)) begin n_err++; $display("FAIL best_index_stable: got %0d want 1", best_index); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_job();
    test_back_to_back();
    test_zero_points();
    test_start_during_stream();
    test_reset_mid_stream();
`ifdef KNN_SEQ_NEAREST_TRACK_EN
    test_nearest_track();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
